regwb_arbiter: RTL and testbench
================================

REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 The block SHALL have input clock, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have input reset, 1 bit: asynchronous, active-high; clock clock.
REQ-003 The block SHALL have inputs alu_valid (1), alu_rd (5), alu_data (64): ALU write-back request.
REQ-004 The block SHALL have output alu_ready (1): ALU request accepted this cycle.
REQ-005 The block SHALL have inputs mem_valid (1), mem_rd (5), mem_data (64): load write-back request.
REQ-006 The block SHALL have output mem_ready (1): load request accepted this cycle.
REQ-007 The block SHALL have input hold (1): when high, no request is granted.
REQ-008 The block SHALL have inputs issue_valid (1) and issue_rd (5): an instruction is issued with destination issue_rd.
REQ-009 The block SHALL have outputs write (1), regwriteaddress (5) and datain (64), which drive the register-file write port.
REQ-010 The block SHALL have output pending (32): scoreboard bit per register, set while a write is outstanding.
REQ-011 The block SHALL have output last_grant (1), where 0 = ALU and 1 = MEM: the most recent granted source.

Function
REQ-012 Grant is combinational from the current inputs and state: at most one of alu_ready and mem_ready SHALL be high in any cycle.
REQ-013 With hold=1, alu_ready=mem_ready=0.
REQ-014 With hold=0 and only one valid request, that requester SHALL be granted.
REQ-015 With hold=0 and both valid, the source not equal to last_grant SHALL be granted (round-robin).
REQ-016 last_grant SHALL update on the clock edge of every grant and hold otherwise.
REQ-017 A handshake completes when valid and ready are both high; the requester holds rd/data stable until it sees ready.
REQ-018 Latency: a request accepted in cycle N SHALL appear registered in cycle N+1 as write=1, regwriteaddress=rd, datain=data.
REQ-019 Any cycle after a cycle with no grant SHALL have write=0; regwriteaddress and datain hold their previous values.
REQ-020 An accepted request with rd=0 SHALL complete its handshake, but write SHALL be 0 in cycle N+1 (writes to x0 are discarded).
REQ-021 Scoreboard set: issue_valid=1 with issue_rd≠0 SHALL set pending[issue_rd] on the clock edge.
REQ-022 Scoreboard clear: a registered write (write=1) to address A SHALL clear pending[A] on the clock edge at the end of that write cycle.
REQ-023 Simultaneous set and clear of the same register in one cycle SHALL leave the bit set (new issue wins).
REQ-024 pending[0] SHALL be 0 at all times.
REQ-025 Simultaneous set and clear of different registers SHALL both take effect.
REQ-026 Throughput: one write per cycle is sustained when any request is valid every cycle and hold=0.

Reset
REQ-027 reset=1 SHALL asynchronously force write=0, regwriteaddress=0, datain=0, pending=0 and last_grant=1 (MEM), so the first tie goes to the ALU.
REQ-028 While reset=1, alu_ready=mem_ready=0.
REQ-029 A request accepted in the cycle before reset asserts SHALL be dropped: no write after reset releases.
REQ-030 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-031 Reset, then alu_valid=1, alu_rd=5, alu_data=64'hA, mem_valid=0 -> alu_ready=1 in cycle N; cycle N+1 shows write=1, addr=5, datain=64'hA; last_grant=0.
REQ-032 Both valid for 4 consecutive cycles (ALU rd=1, MEM rd=2) with ready-driven advance -> grants alternate ALU, MEM, ALU, MEM; write addresses in cycles N+1..N+4 are 1, 2, 1, 2.
REQ-033 mem_valid=1, mem_rd=0, mem_data=64'hFF -> mem_ready=1; next cycle write=0; pending unchanged.
REQ-034 issue_valid with issue_rd=7 -> pending[7]=1; a later ALU write to rd=7 -> pending[7]=0 after the write cycle; a second issue to rd=7 in the write cycle -> pending[7] remains 1.
REQ-035 hold=1 for 3 cycles with both requests valid -> no ready and write=0 throughout; after hold=0, the ALU is granted first if last_grant=1.
REQ-036 Assert reset mid-stream while a grant is in flight -> write=0 and pending=0 immediately (asynchronously); no write occurs after release until a new grant.

Source files
------------

// File: rtl/regwb_arbiter_if.sv
// Purpose: bundles the two write-back request channels, hold, issue and register-file write signals.
// Latency: n/a (signal bundle only).
// Backpressure: alu_ready/mem_ready are driven by the arbiter and gate the valid/ready handshakes.
// Ports: slave modport is the arbiter's view; master modport is the requesters' and consumers' view.
interface regwb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        hold;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        write;
  logic [4:0]  regwriteaddress;
  logic [63:0] datain;
  logic [31:0] pending;
  logic        last_grant;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  hold, issue_valid, issue_rd,
    output alu_ready, mem_ready, write, regwriteaddress, datain, pending, last_grant
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output hold, issue_valid, issue_rd,
    input  alu_ready, mem_ready, write, regwriteaddress, datain, pending, last_grant
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Purpose: round-robin arbiter between ALU and load write-back onto one register-file write port, plus pending scoreboard.
// Latency: a request accepted in cycle N is presented as a registered write in cycle N+1.
// Backpressure: at most one of alu_ready/mem_ready per cycle; both are low while hold or reset is high.
// Ports: clock, reset (async, active-high) and bus (slave modport) carrying requests, readies, write port, pending, last_grant.
module regwb_arbiter (
  input  logic              clock,
  input  logic              reset,
  regwb_arbiter_if.slave    bus
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic        alu_grant;
  logic        mem_grant;
  logic        write_q;
  logic [4:0]  addr_q;
  logic [63:0] data_q;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        last_q;

  // A tie goes to whichever source was not granted last; reset gating keeps
  // the readies low for the whole reset pulse, not just after the first edge.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!reset && !bus.hold) begin
      if (bus.alu_valid && bus.mem_valid) begin
        alu_grant = (last_q == SRC_MEM);
        mem_grant = (last_q == SRC_ALU);
      end else begin
        alu_grant = bus.alu_valid;
        mem_grant = bus.mem_valid;
      end
    end
  end

  // Clear from the write presented this cycle is applied first so that a
  // same-register issue in the same cycle leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (write_q) begin
      pending_d[addr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q   <= 1'b0;
      addr_q    <= 5'd0;
      data_q    <= 64'd0;
      pending_q <= 32'd0;
      last_q    <= SRC_MEM;
    end else begin
      pending_q <= pending_d;
      if (alu_grant) begin
        // x0 writes still complete the handshake but never reach the file.
        write_q <= (bus.alu_rd != 5'd0);
        addr_q  <= bus.alu_rd;
        data_q  <= bus.alu_data;
        last_q  <= SRC_ALU;
      end else if (mem_grant) begin
        write_q <= (bus.mem_rd != 5'd0);
        addr_q  <= bus.mem_rd;
        data_q  <= bus.mem_data;
        last_q  <= SRC_MEM;
      end else begin
        write_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready       = alu_grant;
  assign bus.mem_ready       = mem_grant;
  assign bus.write           = write_q;
  assign bus.regwriteaddress = addr_q;
  assign bus.datain          = data_q;
  assign bus.pending         = pending_q;
  assign bus.last_grant      = last_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Purpose: self-checking bench for regwb_arbiter with a grant/pending model and a write scoreboard.
// Latency: expects accepted requests to appear as writes one cycle later.
// Backpressure: drives hold and simultaneous requests to exercise round-robin and stalls.
module tb_regwb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic clock;
  logic reset;
  regwb_arbiter_if bus ();

  regwb_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];

  // model state
  logic        m_write;
  logic [4:0]  m_addr;
  logic [31:0] m_pending;
  logic        m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares outputs against the model at each falling edge and
  // advances the model to what the next rising edge should produce.
  always @(negedge clock) begin
    logic        g_alu;
    logic        g_mem;
    logic [31:0] np;
    wr_t         w;
    if (reset) begin
      check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
      check("rst_write", 64'(bus.write), 64'd0);
      check("rst_pending", 64'(bus.pending), 64'd0);
      check("rst_last_grant", 64'(bus.last_grant), 64'd1);
      m_write   = 1'b0;
      m_addr    = 5'd0;
      m_pending = 32'd0;
      m_last    = 1'b1;
      exp_q.delete();
    end else begin
      g_alu = !bus.hold && bus.alu_valid && (!bus.mem_valid || m_last);
      g_mem = !bus.hold && bus.mem_valid && (!bus.alu_valid || !m_last);
      check("mon_alu_ready", 64'(bus.alu_ready), 64'(g_alu));
      check("mon_mem_ready", 64'(bus.mem_ready), 64'(g_mem));
      check("mon_write", 64'(bus.write), 64'(m_write));
      check("mon_pending", 64'(bus.pending), 64'(m_pending));
      check("mon_last_grant", 64'(bus.last_grant), 64'(m_last));
      if (bus.write) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 64'(bus.regwriteaddress), 64'h1_0000);
        end else begin
          w = exp_q.pop_front();
          check("sb_addr", 64'(bus.regwriteaddress), 64'(w.rd));
          check("sb_data", bus.datain, w.data);
        end
      end
      np = m_pending;
      if (m_write) np[m_addr] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 5'd0) np[bus.issue_rd] = 1'b1;
      np[0] = 1'b0;
      m_pending = np;
      if (g_alu) begin
        m_write = (bus.alu_rd != 5'd0);
        m_addr  = bus.alu_rd;
        m_last  = 1'b0;
        if (m_write) exp_q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      end else if (g_mem) begin
        m_write = (bus.mem_rd != 5'd0);
        m_addr  = bus.mem_rd;
        m_last  = 1'b1;
        if (m_write) exp_q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      end else begin
        m_write = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] psave;
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.hold = 0; bus.issue_valid = 0; bus.issue_rd = 0;
    repeat (3) step();
    reset = 1'b0;

    // single ALU request
    step();
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 64'hA;
    @(negedge clock);
    check("alu_only_ready", 64'(bus.alu_ready), 64'd1);
    step();
    bus.alu_valid = 0;
    check("alu_only_write", 64'(bus.write), 64'd1);
    check("alu_only_addr", 64'(bus.regwriteaddress), 64'd5);
    check("alu_only_data", bus.datain, 64'hA);
    check("alu_only_last", 64'(bus.last_grant), 64'd0);

    // load to x0: handshake completes, no write, pending unchanged
    bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_data = 64'hFF;
    @(negedge clock);
    check("x0_ready", 64'(bus.mem_ready), 64'd1);
    psave = bus.pending;
    step();
    bus.mem_valid = 0;
    check("x0_write", 64'(bus.write), 64'd0);
    check("x0_pending", 64'(bus.pending), 64'(psave));
    check("x0_last", 64'(bus.last_grant), 64'd1);

    // both valid: grants alternate starting with ALU
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 64'h1100;
    bus.mem_valid = 1; bus.mem_rd = 5'd2; bus.mem_data = 64'h2200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rr_grant", 64'({bus.alu_ready, bus.mem_ready}), (i % 2 == 0) ? 64'd2 : 64'd1);
      step();
      check("rr_addr", 64'(bus.regwriteaddress), (i % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_write", 64'(bus.write), 64'd1);
      if (i % 2 == 0) bus.alu_data = bus.alu_data + 64'd1;
      else bus.mem_data = bus.mem_data + 64'd1;
    end
    bus.alu_valid = 0; bus.mem_valid = 0;

    // scoreboard set / clear / same-cycle set wins / different registers
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    check("sb_set7", 64'(bus.pending[7]), 64'd1);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
    step();
    bus.alu_valid = 0;
    check("sb_wcycle_write", 64'(bus.write), 64'd1);
    check("sb_wcycle_pend", 64'(bus.pending[7]), 64'd1);
    step();
    check("sb_clear7", 64'(bus.pending[7]), 64'd0);
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 64'h78;
    step();
    bus.alu_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    check("sb_set_wins", 64'(bus.pending[7]), 64'd1);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 64'h79;
    step();
    bus.alu_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    step();
    bus.issue_valid = 0;
    check("sb_diff_clr", 64'(bus.pending[7]), 64'd0);
    check("sb_diff_set", 64'(bus.pending[9]), 64'd1);

    // hold: no grants and no writes, then ALU first after a MEM grant
    bus.mem_valid = 1; bus.mem_rd = 5'd3; bus.mem_data = 64'h33;
    step();
    bus.mem_valid = 0;
    bus.hold = 1;
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
    bus.mem_valid = 1; bus.mem_rd = 5'd6; bus.mem_data = 64'h66;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ready", 64'({bus.alu_ready, bus.mem_ready}), 64'd0);
      check("hold_write", 64'(bus.write), 64'd0);
    end
    bus.hold = 0;
    @(negedge clock);
    check("hold_alu_first", 64'(bus.alu_ready), 64'd1);
    step();
    bus.alu_valid = 0;
    @(negedge clock);
    check("hold_mem_next", 64'(bus.mem_ready), 64'd1);
    step();
    bus.mem_valid = 0;

    // reset while a write is in flight
    bus.issue_valid = 1; bus.issue_rd = 5'd12;
    bus.alu_valid = 1; bus.alu_rd = 5'd8; bus.alu_data = 64'h88;
    step();
    bus.issue_valid = 0;
    bus.alu_valid = 0;
    reset = 1'b1;
    #1;
    check("arst_write", 64'(bus.write), 64'd0);
    check("arst_pending", 64'(bus.pending), 64'd0);
    check("arst_addr", 64'(bus.regwriteaddress), 64'd0);
    check("arst_data", bus.datain, 64'd0);
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_write", 64'(bus.write), 64'd0);
    end
    bus.mem_valid = 1; bus.mem_rd = 5'd10; bus.mem_data = 64'hAB;
    @(negedge clock);
    check("post_rst_tie_free", 64'(bus.mem_ready), 64'd1);
    step();
    bus.mem_valid = 0;
    check("post_rst_resume", 64'(bus.write), 64'd1);
    repeat (2) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
